// File: rtl/multiplicador_fd.sv
// Shift-and-add unsigned multiplier datapath: B, A/C accumulator, Q shifter and iteration counter.
// Optional MULT_PRODUCT_REG_EN registers the product on the done strobe and holds it across operations.
module multiplicador_fd #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_a_rst,
  input  logic           i_a_en,
  input  logic           i_a_ld,
  input  logic           i_b_en,
  input  logic           i_b_ld,
  input  logic           i_q_en,
  input  logic           i_q_ld,
  input  logic           i_cnt_en,
  input  logic           i_cnt_ld,
  input  logic           i_done,
  input  logic [N-1:0]   i_md,
  input  logic [N-1:0]   i_mr,
  output logic           o_qlsb,
  output logic           o_zero,
  output logic [2*N-1:0] o_product,
  output logic           o_product_valid
);

  logic [N-1:0]  r_b;
  logic [N-1:0]  r_a;
  logic          r_c;
  logic [N-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic [N:0]    w_sum;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_b <= '0;
    end else if (i_b_en && i_b_ld) begin
      r_b <= i_md;
    end
  end

  // The clear wins over any add or shift requested in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c <= 1'b0;
      r_a <= '0;
    end else if (i_a_rst) begin
      r_c <= 1'b0;
      r_a <= '0;
    end else if (i_a_en) begin
      if (i_a_ld) begin
        {r_c, r_a} <= w_sum;
      end else begin
        {r_c, r_a} <= {1'b0, r_c, r_a[N-1:1]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_q_en) begin
      if (i_q_ld) begin
        r_q <= i_mr;
      end else begin
        r_q <= {r_a[0], r_q[N-1:1]};
      end
    end
  end

  // Counts down and saturates at zero instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_cnt_en) begin
      if (i_cnt_ld) begin
        r_cnt <= CW'(N);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_qlsb = r_q[0];
  assign o_zero = (r_cnt == '0);

`ifdef MULT_PRODUCT_REG_EN
  logic [2*N-1:0] r_product;
  logic           r_product_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_product       <= '0;
      r_product_valid <= 1'b0;
    end else if (i_done) begin
      r_product       <= {r_a, r_q};
      r_product_valid <= 1'b1;
    end else if (i_q_en && i_q_ld) begin
      r_product_valid <= 1'b0;
    end
  end

  assign o_product       = r_product;
  assign o_product_valid = r_product_valid;
`else
  assign o_product       = {r_a, r_q};
  assign o_product_valid = i_done;
`endif

endmodule

// File: tb/tb_multiplicador_fd.sv
// Directed self-checking bench for multiplicador_fd (N=8), covering both product-output builds.
module tb_multiplicador_fd;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic           clk;
  logic           rst;
  logic           aRst, aEn, aLd, bEn, bLd, qEn, qLd, cntEn, cntLd, done;
  logic [N-1:0]   md, mr;
  logic           qlsb, zero, productValid;
  logic [2*N-1:0] product;

  int compareCount = 0;
  int failCount    = 0;

  multiplicador_fd #(.N(N), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_a_rst(aRst),
    .i_a_en(aEn), .i_a_ld(aLd), .i_b_en(bEn), .i_b_ld(bLd),
    .i_q_en(qEn), .i_q_ld(qLd), .i_cnt_en(cntEn), .i_cnt_ld(cntLd),
    .i_done(done), .i_md(md), .i_mr(mr),
    .o_qlsb(qlsb), .o_zero(zero), .o_product(product),
    .o_product_valid(productValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aRst = 0; aEn = 0; aLd = 0; bEn = 0; bLd = 0;
    qEn = 0; qLd = 0; cntEn = 0; cntLd = 0; done = 0;
  endtask

  task automatic loadOps(input logic [N-1:0] m, input logic [N-1:0] r);
    idle();
    md = m; mr = r;
    aRst = 1; bEn = 1; bLd = 1; qEn = 1; qLd = 1; cntEn = 1; cntLd = 1;
    tick();
    idle();
  endtask

  task automatic addStep();
    idle(); aEn = 1; aLd = 1;
    tick();
    idle();
  endtask

  task automatic shiftStep();
    idle(); aEn = 1; qEn = 1; cntEn = 1;
    tick();
    idle();
  endtask

  task automatic runIterations(input int maxIter, output int shifts);
    shifts = 0;
    while (!zero && shifts < maxIter) begin
      if (qlsb) addStep();
      shiftStep();
      shifts++;
    end
  endtask

  // With the registered product the result must be captured with a done pulse
  // before it is visible; all enables stay low so the datapath holds.
  task automatic observe();
`ifdef MULT_PRODUCT_REG_EN
    idle(); done = 1;
    tick();
    idle();
`endif
  endtask

  task automatic test_reset();
    idle(); md = '0; mr = '0;
    rst = 1;
    #1;
    compareCount++; if (qlsb !== 1'b0) begin failCount++; $display("[TB] FAIL reset_qlsb: got %b want 0", qlsb); end
    compareCount++; if (zero !== 1'b1) begin failCount++; $display("[TB] FAIL reset_zero: got %b want 1", zero); end
    compareCount++; if (product !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_product: got %h want 0000", product); end
    compareCount++; if (productValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b want 0", productValid); end
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic test_13x11();
    int shifts;
    loadOps(8'd13, 8'd11);
    compareCount++; if (qlsb !== 1'b1) begin failCount++; $display("[TB] FAIL m13x11_load_qlsb: got %b want 1", qlsb); end
    compareCount++; if (zero !== 1'b0) begin failCount++; $display("[TB] FAIL m13x11_load_zero: got %b want 0", zero); end
    runIterations(2 * N + 2, shifts);
    compareCount++; if (shifts !== 8) begin failCount++; $display("[TB] FAIL m13x11_shifts: got %0d want 8", shifts); end
    compareCount++; if (zero !== 1'b1) begin failCount++; $display("[TB] FAIL m13x11_zero: got %b want 1", zero); end
`ifdef MULT_PRODUCT_REG_EN
    done = 1;
    tick();
    idle();
    compareCount++; if (productValid !== 1'b1) begin failCount++; $display("[TB] FAIL m13x11_valid: got %b want 1", productValid); end
`else
    done = 1;
    #1;
    compareCount++; if (productValid !== 1'b1) begin failCount++; $display("[TB] FAIL m13x11_valid: got %b want 1", productValid); end
    tick();
    idle();
    #1;
    compareCount++; if (productValid !== 1'b0) begin failCount++; $display("[TB] FAIL m13x11_valid_drop: got %b want 0", productValid); end
`endif
    compareCount++; if (product !== 16'h008F) begin failCount++; $display("[TB] FAIL m13x11_product: got %h want 008f", product); end
  endtask

  task automatic test_255x255();
    int shifts;
    loadOps(8'd255, 8'd255);
    runIterations(2 * N + 2, shifts);
    observe();
    compareCount++; if (product !== 16'hFE01) begin failCount++; $display("[TB] FAIL m255x255_product: got %h want fe01", product); end
    compareCount++; if (shifts !== 8) begin failCount++; $display("[TB] FAIL m255x255_shifts: got %0d want 8", shifts); end
  endtask

  task automatic test_zero_operands();
    int shifts;
    logic [N-1:0] mrBits;
    mrBits = 8'd200;
    loadOps(8'd0, mrBits);
    for (int i = 0; i < N; i++) begin
      compareCount++; if (qlsb !== mrBits[i]) begin failCount++; $display("[TB] FAIL zero_md_qlsb%0d: got %b want %b", i, qlsb, mrBits[i]); end
      if (qlsb) addStep();
      shiftStep();
    end
    observe();
    compareCount++; if (product !== 16'h0000) begin failCount++; $display("[TB] FAIL m0x200_product: got %h want 0000", product); end
    compareCount++; if (zero !== 1'b1) begin failCount++; $display("[TB] FAIL m0x200_zero: got %b want 1", zero); end
    loadOps(8'd200, 8'd0);
    runIterations(2 * N + 2, shifts);
    observe();
    compareCount++; if (product !== 16'h0000) begin failCount++; $display("[TB] FAIL m200x0_product: got %h want 0000", product); end
  endtask

  task automatic test_hold();
    int shifts;
    loadOps(8'd13, 8'd11);
    for (int i = 0; i < 5; i++) tick();
    compareCount++; if (zero !== 1'b0) begin failCount++; $display("[TB] FAIL hold_zero: got %b want 0", zero); end
    compareCount++; if (qlsb !== 1'b1) begin failCount++; $display("[TB] FAIL hold_qlsb: got %b want 1", qlsb); end
    observe();
    compareCount++; if (product !== 16'h000B) begin failCount++; $display("[TB] FAIL hold_product: got %h want 000b", product); end
    runIterations(2 * N + 2, shifts);
    compareCount++; if (shifts !== 8) begin failCount++; $display("[TB] FAIL hold_shifts: got %0d want 8", shifts); end
    idle(); cntEn = 1;
    tick(); tick();
    idle();
    compareCount++; if (zero !== 1'b1) begin failCount++; $display("[TB] FAIL cnt_saturate: got %b want 1", zero); end
    observe();
    compareCount++; if (product !== 16'h008F) begin failCount++; $display("[TB] FAIL hold_product_end: got %h want 008f", product); end
  endtask

  task automatic test_partial_shift();
    loadOps(8'h03, 8'h00);
    addStep();
    idle(); qEn = 1;
    tick();
    idle();
    observe();
    compareCount++; if (product !== 16'h0380) begin failCount++; $display("[TB] FAIL q_only_shift: got %h want 0380", product); end
    idle(); aEn = 1;
    tick();
    idle();
    observe();
    compareCount++; if (product !== 16'h0180) begin failCount++; $display("[TB] FAIL a_only_shift: got %h want 0180", product); end
  endtask

  task automatic test_reset_mid_op();
    int shifts;
    loadOps(8'd13, 8'd11);
    runIterations(3, shifts);
    #2 rst = 1;
    #1;
    compareCount++; if (zero !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_zero: got %b want 1", zero); end
    compareCount++; if (qlsb !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_qlsb: got %b want 0", qlsb); end
    compareCount++; if (product !== 16'h0000) begin failCount++; $display("[TB] FAIL midrst_product: got %h want 0000", product); end
    #2 rst = 0;
    loadOps(8'd6, 8'd7);
    runIterations(2 * N + 2, shifts);
    observe();
    compareCount++; if (product !== 16'd42) begin failCount++; $display("[TB] FAIL m6x7_product: got %h want 002a", product); end
  endtask

`ifdef MULT_PRODUCT_REG_EN
  task automatic test_product_reg();
    int shifts;
    loadOps(8'd13, 8'd11);
    runIterations(2 * N + 2, shifts);
    observe();
    loadOps(8'd6, 8'd7);
    compareCount++; if (productValid !== 1'b0) begin failCount++; $display("[TB] FAIL preg_valid_clear: got %b want 0", productValid); end
    compareCount++; if (product !== 16'h008F) begin failCount++; $display("[TB] FAIL preg_hold_143: got %h want 008f", product); end
    runIterations(2 * N + 2, shifts);
    compareCount++; if (product !== 16'h008F) begin failCount++; $display("[TB] FAIL preg_hold_end: got %h want 008f", product); end
    observe();
    compareCount++; if (product !== 16'd42) begin failCount++; $display("[TB] FAIL preg_product_42: got %h want 002a", product); end
    compareCount++; if (productValid !== 1'b1) begin failCount++; $display("[TB] FAIL preg_valid_set: got %b want 1", productValid); end
  endtask
`endif

  initial begin
    rst = 1;
    idle();
    md = '0; mr = '0;
    test_reset();
    test_13x11();
    test_255x255();
    test_zero_operands();
    test_hold();
    test_partial_shift();
    test_reset_mid_op();
`ifdef MULT_PRODUCT_REG_EN
    test_product_reg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/multiplicador_fd.md
# multiplicador_fd

Datapath of the shift-and-add unsigned multiplier, driven by the `multiplicador_uc` control unit. It holds:
- the multiplicand register B;
- the accumulator A with its carry bit C;
- the multiplier/low-product shift register Q;
- the iteration counter.

It returns the `qlsb` and `zero` status flags to the control unit and presents the 2N-bit product.

## Interface
- `N`, 8: operand width in bits (N ≥ 2).
- `CW`, `$clog2(N+1)`: counter width.

Ports:
- `clk` in 1: sole clock. All registers update on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_rst` in 1: synchronous clear of A and C.
- `a_en`, `a_ld` in 1: A/C register enable and load.
- `b_en`, `b_ld` in 1: B register enable and load.
- `q_en`, `q_ld` in 1: Q register enable and load.
- `cnt_en`, `cnt_ld` in 1: counter enable and load.
- `done` in 1: end-of-operation strobe from the control unit.
- `md` in N: multiplicand operand.
- `mr` in N: multiplier operand.
- `qlsb` out 1: Q[0].
- `zero` out 1: high when counter == 0.
- `product` out 2N: the {A,Q} result.
- `product_valid` out 1: product-register valid flag (see Configuration).

## Operation
Each register follows one rule: `en`=0 holds; `en`=1,`ld`=1 loads; `en`=1,`ld`=0 shifts or counts.

- **B:** load ← `md`. With `b_ld`=0, B holds regardless of `b_en`.
- **Q:** load ← `mr`. Shift: Q ← {A[0], Q[N-1:1]}, where A[0] is the pre-edge value.
- **A/C:**
  - `a_rst`=1 → A←0, C←0. This has priority over `a_en`/`a_ld`.
  - Load → {C,A} ← A + B, computed as an (N+1)-bit sum of the pre-edge values.
  - Shift → {C,A} ← {0, C, A[N-1:1]}.
- **Counter:** load ← N. Count → cnt ← cnt − 1. At 0 it saturates at 0; there is no wrap-around.
- **Status flags:** `qlsb` = Q[0] and `zero` = (cnt == 0). Both are purely combinational from register outputs.
- **Product:** combinational `product` = {A,Q}, unless `MULT_PRODUCT_REG_EN` is defined (see Configuration).

Intended sequence, per control-unit step:
- **Load:** `a_rst`, `b_en/b_ld`, `q_en/q_ld`, `cnt_en/cnt_ld`.
- **Per iteration:**
  - add step (`a_en`,`a_ld`) when `qlsb`=1;
  - then shift step (`a_en`,`q_en`,`cnt_en` with ld=0).
- Repeat the iteration until `zero`.

Simultaneous-event rules:
- A shift and a Q shift in the same cycle form one combined right shift of {C,A,Q}.
- If Q shifts while A holds, Q still takes A[0]. If A shifts while Q holds, A[0] is lost.
- Load with shift on a different register in the same cycle: each register uses only pre-edge values, so there are no read-after-write hazards.

## Timing
- Register updates take effect 1 cycle after the control strobe. `qlsb` and `zero` reflect them in that same following cycle, with 0-cycle combinational delay.
- Full multiply: 1 load cycle + N × (1 optional add + 1 shift) = N+1 to 2N+1 cycles.
- `rst` asserted clears immediately (async) and holds while high: A, C, B, Q, counter, product register, and `product_valid` all go to 0. `qlsb`=0, `zero`=1, `product`=0.
- Reset mid-operation aborts the operation with no partial result retained. The first edge after `rst` deasserts obeys the control inputs normally.
- Counter-load overflow is impossible: `CW` covers the value N.

## Configuration
Macro: `MULT_PRODUCT_REG_EN`.

Defined:
- `product` is a 2N-bit register loaded with {A,Q} on the edge where `done`=1. `product_valid` is set on that edge.
- `product_valid` clears on the next load cycle (`q_en`&`q_ld`) or on `rst`.
- The product therefore stays stable while a new multiply runs.

Undefined:
- `product` = {A,Q} combinationally. It is valid only while the control unit holds `done`.
- `product_valid` = `done`. `done` is otherwise ignored.

## Test plan
- **13 × 11, N=8:** load, then drive the add/shift sequence by `qlsb` → after 8 shifts `zero`=1 and `product`=143 (0x008F).
- **255 × 255:** every iteration adds. C must carry into the shift → `product`=65025 (0xFE01).
- **0 × 200 and 200 × 0:** → `product`=0. With `md`=0, `qlsb` follows `mr` bits and A stays 0.
- **All `en`=0 for 5 cycles after load:** A, B, Q, counter unchanged. Extra `cnt_en` at 0 → count stays 0.
- **Reset mid-operation:** assert `rst` after 3 shifts of 13×11, between edges → all outputs 0 immediately, `zero`=1. A following 6×7 run yields 42.
- **With `MULT_PRODUCT_REG_EN`:** 13×11 with `done` pulse → `product`=143 and `product_valid`=1. Start 6×7 → `product_valid`=0 after the load edge, and `product` holds 143 until the next `done`, then shows 42.
